// File: rtl/edge_period_meter.sv
// Slow square-wave meter: synchronises sig_in, strobes edges,
// measures rise-to-rise period and high time, flags a stalled input.
module edge_period_meter #(
  parameter int CNT_W   = 26,
  parameter int TIMEOUT = 50_000_000 - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             period_valid,
  output logic             stalled
);

  typedef enum logic [1:0] {
    ARM   = 2'd0,
    MEAS  = 2'd1,
    STALL = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TO  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state_q;
  logic             s1_q, s2_q, prev_q;
  logic             rise_q, fall_q;
  logic             valid_q, stalled_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, high_q;
  logic [CNT_W-1:0] cnt_inc;
  logic             rise_d, fall_d, tmo;

  assign rise_d  = s2_q & ~prev_q;
  assign fall_d  = ~s2_q & prev_q;
  assign tmo     = (cnt_q == TO);
  assign cnt_inc = cnt_q + ONE;

  always_comb begin
    cnt_d = cnt_inc;
    if (rise_d) begin
      cnt_d = '0;
    end else if (tmo) begin
      cnt_d = TO;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      prev_q    <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      cnt_q     <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      stalled_q <= 1'b0;
      state_q   <= ARM;
    end else begin
      s1_q   <= sig_in;
      s2_q   <= s1_q;
      prev_q <= s2_q;
      rise_q <= rise_d;
      fall_q <= fall_d;
      cnt_q  <= cnt_d;
      unique case (state_q)
        ARM: begin
          if (rise_d) begin
            state_q   <= MEAS;
            stalled_q <= 1'b0;
          end else if (tmo) begin
            stalled_q <= 1'b1;
          end
        end
        MEAS: begin
          if (fall_d) begin
            high_q <= cnt_inc;
          end
          if (rise_d) begin
            period_q <= cnt_inc;
            valid_q  <= 1'b1;
          end else if (tmo) begin
            // stall entry wipes any fall captured on this edge
            state_q   <= STALL;
            stalled_q <= 1'b1;
            valid_q   <= 1'b0;
            period_q  <= '0;
            high_q    <= '0;
          end
        end
        STALL: begin
          if (rise_d) begin
            state_q   <= MEAS;
            stalled_q <= 1'b0;
          end
        end
        default: state_q <= ARM;
      endcase
    end
  end

  assign rise_pulse   = rise_q;
  assign fall_pulse   = fall_q;
  assign period       = period_q;
  assign high_time    = high_q;
  assign period_valid = valid_q;
  assign stalled      = stalled_q;

endmodule

// File: tb/tb_edge_period_meter.sv
// Bench for edge_period_meter: directed phases plus random waves,
// checked every cycle against a timestamp-based reference model.
module tb_edge_period_meter;

  localparam int CNT_W = 12;
  localparam int TO    = 1000;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             sig_in = 1'b0;
  logic             rise_pulse, fall_pulse;
  logic [CNT_W-1:0] period, high_time;
  logic             period_valid, stalled;

  edge_period_meter #(
    .CNT_W  (CNT_W),
    .TIMEOUT(TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sig_in      (sig_in),
    .rise_pulse  (rise_pulse),
    .fall_pulse  (fall_pulse),
    .period      (period),
    .high_time   (high_time),
    .period_valid(period_valid),
    .stalled     (stalled)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // model: edge index, timestamp of last rise/reset, mode 0/1/2
  int n = 0;
  int ref_e = 0;
  int mode = 0;
  bit hist[$];
  bit m_rise, m_fall, m_valid, m_stalled;
  int m_period, m_high;

  task automatic model_clear();
    hist = '{1'b0, 1'b0, 1'b0};
    ref_e = n;
    mode = 0;
    m_rise = 0;
    m_fall = 0;
    m_valid = 0;
    m_stalled = 0;
    m_period = 0;
    m_high = 0;
  endtask

  task automatic model_step(input bit r, input bit s);
    bit rs, fl;
    int el;
    n++;
    if (!r) begin
      model_clear();
    end else begin
      // hist[0]=newest sample, hist[1]=sync level, hist[2]=previous
      rs = hist[1] & !hist[2];
      fl = !hist[1] & hist[2];
      el = n - ref_e;
      m_rise = rs;
      m_fall = fl;
      if (rs) begin
        if (mode == 1) begin
          m_period = el;
          m_valid = 1;
        end else begin
          mode = 1;
          m_stalled = 0;
        end
        ref_e = n;
      end else begin
        if (fl && mode == 1) m_high = el;
        if (el > TO) begin
          if (mode == 0) begin
            m_stalled = 1;
          end else if (mode == 1) begin
            mode = 2;
            m_stalled = 1;
            m_valid = 0;
            m_period = 0;
            m_high = 0;
          end
        end
      end
      hist.push_front(s);
      void'(hist.pop_back());
    end
  endtask

  task automatic cycle(input bit r, input bit s);
    rst = r;
    sig_in = s;
    @(posedge clk);
    model_step(r, s);
    @(negedge clk);
    chk("rise", int'(rise_pulse), int'(m_rise));
    chk("fall", int'(fall_pulse), int'(m_fall));
    chk("period", int'(period), m_period);
    chk("high", int'(high_time), m_high);
    chk("valid", int'(period_valid), int'(m_valid));
    chk("stall", int'(stalled), int'(m_stalled));
  endtask

  task automatic hold(input bit s, input int cyc);
    for (int i = 0; i < cyc; i++) cycle(1'b1, s);
  endtask

  task automatic wave(input int p, input int h, input int reps);
    for (int i = 0; i < reps; i++) begin
      hold(1'b1, h);
      hold(1'b0, p - h);
    end
  endtask

  int seen;
  int rises;
  int rise_at;

  initial begin
    model_clear();

    // reset held with input toggling
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, i[0]);
      chk("rst_rise", int'(rise_pulse), 0);
      chk("rst_period", int'(period), 0);
    end
    rises = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0);
      rises += int'(rise_pulse);
    end
    chk("idle_rises", rises, 0);

    // 100/40 wave
    hold(1'b1, 40);
    chk("first_valid", int'(period_valid), 0);
    hold(1'b0, 60);
    chk("first_high", int'(high_time), 40);
    wave(100, 40, 2);
    chk("p100", int'(period), 100);
    chk("p100_valid", int'(period_valid), 1);

    // 250/125 wave
    wave(250, 125, 2);
    chk("p250", int'(period), 250);
    chk("h125", int'(high_time), 125);

    // stall then recovery
    hold(1'b0, 1100);
    chk("stall_flag", int'(stalled), 1);
    chk("stall_valid", int'(period_valid), 0);
    chk("stall_period", int'(period), 0);
    chk("stall_high", int'(high_time), 0);
    hold(1'b1, 1);
    hold(1'b0, 10);
    chk("rearm_stall", int'(stalled), 0);
    chk("rearm_period", int'(period), 0);
    chk("rearm_valid", int'(period_valid), 0);
    wave(100, 40, 3);
    chk("resume_p", int'(period), 100);
    chk("resume_valid", int'(period_valid), 1);

    // spacing 1001: no stall
    seen = 0;
    for (int i = 0; i < 1006; i++) begin
      cycle(1'b1, i < 40 || i >= 1001);
      seen |= int'(stalled);
    end
    chk("p1001", int'(period), 1001);
    chk("p1001_nostall", seen, 0);

    // spacing 1002: stall before the rise
    seen = 0;
    for (int i = 0; i < 1002; i++) begin
      cycle(1'b1, i < 35 || i >= 997);
      seen |= int'(stalled);
    end
    chk("p1002_stall", seen, 1);
    chk("p1002_clear", int'(stalled), 0);
    chk("p1002_valid", int'(period_valid), 0);

    // reset mid-period with input high
    hold(1'b0, 60);
    wave(100, 40, 2);
    hold(1'b1, 20);
    cycle(1'b0, 1'b1);
    chk("mid_rst_period", int'(period), 0);
    chk("mid_rst_high", int'(high_time), 0);
    chk("mid_rst_valid", int'(period_valid), 0);
    rises = 0;
    rise_at = 0;
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, 1'b1);
      if (rise_pulse) begin
        rises++;
        rise_at = i;
      end
    end
    chk("rel_rises", rises, 1);
    chk("rel_rise_at", rise_at, 3);
    chk("rel_valid", int'(period_valid), 0);
    hold(1'b0, 60);
    wave(100, 40, 2);
    chk("rel_p", int'(period), 100);
    chk("rel_p_valid", int'(period_valid), 1);

    // random waves with occasional reset
    for (int k = 0; k < 30; k++) begin
      int p, h;
      p = int'($urandom_range(2, 1100));
      h = int'($urandom_range(1, p - 1));
      if ($urandom_range(0, 9) == 0) cycle(1'b0, 1'($urandom));
      wave(p, h, 1);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
